// File: rtl/count_loader_if.sv
// Host write channel into the count_loader start-value queue.
// The host side uses the master modport and the loader uses the slave modport.
interface count_loader_if #(
   parameter int unsigned W = 8
);
   logic         wr_valid;
   logic         wr_ready;
   logic [W-1:0] wr_data;

   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready
   );
endinterface

// File: rtl/count_loader.sv
// Queues host start values and reloads a downstream load/increment counter
// each time its output reaches the terminal value, giving back-to-back segments.
module count_loader #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   count_loader_if.slave            wr,
   input  logic [W-1:0]             term,
   input  logic [W-1:0]             o_in,
   output logic                     st,
   output logic [W-1:0]             X,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     underrun,
   input  logic                     clr_underrun
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic            st_q, st_d;
   logic [W-1:0]    x_q, x_d;
   logic            busy_q, busy_d;
   logic            underrun_q, underrun_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic [W-1:0]    mem_d [DEPTH];

   logic            wr_ready_int;
   logic            push;
   logic            pop;
   logic            not_empty;
   logic            match;

   // Full is judged on the registered fill alone, so a same-cycle pop never frees a slot.
   assign wr_ready_int = (fill_q != FW'(DEPTH));
   assign push         = wr.wr_valid & wr_ready_int;
   assign not_empty    = (fill_q != '0);
   assign match        = (o_in == term);

   assign wr.wr_ready  = wr_ready_int;
   assign st           = st_q;
   assign X            = x_q;
   assign busy         = busy_q;
   assign fill         = fill_q;
   assign underrun     = underrun_q;

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      st_d       = 1'b0;
      x_d        = x_q;
      underrun_d = underrun_q & ~clr_underrun;

      unique case (state_q)
         IDLE: begin
            if (not_empty) begin
               pop     = 1'b1;
               st_d    = 1'b1;
               x_d     = mem_q[rd_ptr_q];
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (match) begin
               if (not_empty) begin
                  pop     = 1'b1;
                  st_d    = 1'b1;
                  x_d     = mem_q[rd_ptr_q];
                  state_d = LOAD;
               end else begin
                  // Set is applied after the clear so it wins on a collision.
                  underrun_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      fill_d   = fill_q + FW'(push) - FW'(pop);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push) begin
         mem_d[wr_ptr_q] = wr.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         st_q       <= 1'b0;
         x_q        <= '0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_q     <= fill_d;
         st_q       <= st_d;
         x_q        <= x_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

   // Storage needs no reset: the pointers and fill count define which entries are live.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule
